// File: rtl/add_sub_serial.sv
// Bit-serial unsigned add/subtract, LSB-first through one full adder; optional ovf port via ADD_SUB_SERIAL_OVF_EN.
// done pulses WIDTH+1 edges after start is accepted; start outside IDLE is dropped, never queued.
module add_sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef ADD_SUB_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic             b_bit;
  logic             s_bit;
  logic             c_next;
`ifdef ADD_SUB_SERIAL_OVF_EN
  logic             cmsb_q, cmsb_d;
  logic             ovf_q, ovf_d;
`endif

  assign b_bit  = b_q[0] ^ sub_q;
  assign s_bit  = a_q[0] ^ b_bit ^ cy_q;
  assign c_next = (a_q[0] & b_bit) | (a_q[0] & cy_q) | (b_bit & cy_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    shr_d   = shr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
`ifdef ADD_SUB_SERIAL_OVF_EN
    cmsb_d  = cmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          cy_d    = sub;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_END) begin
          // Result register is only written here, so sum never shows partial bits.
          state_d = DONE;
          sum_d   = shr_q;
          cout_d  = cy_q ^ sub_q;
`ifdef ADD_SUB_SERIAL_OVF_EN
          ovf_d   = cmsb_q ^ cy_q;
`endif
        end else begin
          shr_d = {s_bit, shr_q[WIDTH-1:1]};
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          cy_d  = c_next;
          cnt_d = cnt_q + 1'b1;
`ifdef ADD_SUB_SERIAL_OVF_EN
          if (cnt_q == CNT_LAST) cmsb_d = cy_q;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      shr_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_SUB_SERIAL_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shr_q   <= shr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
`ifdef ADD_SUB_SERIAL_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;
`ifdef ADD_SUB_SERIAL_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed-vector bench for add_sub_serial (WIDTH=4); covers ovf when ADD_SUB_SERIAL_OVF_EN is defined.
module tb_add_sub_serial;

  localparam int W = 4;

  logic         clock;
  logic         reset_b;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef ADD_SUB_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_vec;
  int n_bad;
  logic [W-1:0] last_sum;

  add_sub_serial #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
`ifdef ADD_SUB_SERIAL_OVF_EN
    .ovf     (ovf),
`endif
    .c_out   (c_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one operation and checks timing, hold-until-done and the registered result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int  done_at;
    bit  busy_ok;
    bit  hold_ok;
    @(posedge clock); #1;
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; sub = ~ts;
    done_at = -1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) begin
        done_at = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (sum !== last_sum) hold_ok = 1'b0;
    end
    check({tag, "_latency"}, done_at, W + 1);
    check({tag, "_busy_while_shift"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_sum_held"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_sum"}, {28'd0, sum}, {28'd0, es});
    check({tag, "_c_out"}, {31'd0, c_out}, {31'd0, ec});
`ifdef ADD_SUB_SERIAL_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected x flag");
`endif
    @(negedge clock);
    check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, "_sum_after"}, {28'd0, sum}, {28'd0, es});
    last_sum = es;
  endtask

  initial begin
    int dones;
    n_vec    = 0;
    n_bad    = 0;
    last_sum = '0;
    reset_b  = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;

    // Idle after reset: outputs stay at zero with no start.
    #23 reset_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {28'd0, sum}, 32'd0);
      check("rst_c_out", {31'd0, c_out}, 32'd0);
    end

    run_op("add_2_3", 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
    run_op("sub_2_3", 4'd2, 4'd3, 1'b1, 4'd15, 1'b1, 1'b0);
    run_op("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
    run_op("sub_7_7", 4'd7, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    run_op("add_7_1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
    run_op("sub_9_4", 4'd9, 4'd4, 1'b1, 4'd5, 1'b0, 1'b1);

    // Second start during SHIFT must be ignored.
    @(posedge clock); #1;
    a = 4'd1; b = 4'd1; sub = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    a = 4'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("ignore_start_dones", dones, 1);
    check("ignore_start_sum", {28'd0, sum}, 32'd2);
    check("ignore_start_c_out", {31'd0, c_out}, 32'd0);
    last_sum = 4'd2;

    // Reset on the 3rd SHIFT cycle discards the operation at once.
    @(posedge clock); #1;
    a = 4'd5; b = 4'd6; sub = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    reset_b = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sum", {28'd0, sum}, 32'd0);
    check("midrst_c_out", {31'd0, c_out}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_b = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done || busy) dones++;
    end
    check("midrst_no_done", dones, 0);
    last_sum = '0;
    run_op("add_5_6", 4'd5, 4'd6, 1'b0, 4'd11, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
